// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage constants and the queued entry type
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order register queue with push/pop/flush and occupancy count
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && (count != '0);
    // a pop frees the slot being written, so push-while-full is legal alongside it
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch stage: sequential PCs, credit-limited imem requests, decode queue; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch_queue
    import core_pkg::*;
#(
    parameter int              XLEN       = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              PC_STEP    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall,
`endif
    output logic [XLEN-1:0] dec_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic            req_fire;
    logic            rsp_retire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            dec_fire;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // queued words plus outstanding requests never exceed the queue, so responses always fit
    assign imem_req_valid = !rst && (({1'b0, count} + {1'b0, inflight}) < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_retire    = imem_rsp_valid && (inflight != '0);
    assign rsp_drop      = rsp_retire && (redirect_valid || (drop != '0));
    assign rsp_keep      = rsp_retire && !rsp_drop;
    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_retire);

    assign dec_valid = (count != '0);
    assign dec_fire  = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? head_entry.instr : '0;
    assign dec_pc    = dec_valid ? head_entry.pc : '0;

    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    // everything still outstanding after this cycle belongs to the old path, including a same-cycle accept
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= '0;
        end else if (redirect_valid) begin
            drop <= inflight_next;
        end else if (rsp_drop) begin
            drop <= drop - 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_retire),
        .flush     (1'b0),
        .head      (rsp_pc),
        .count     (inflight)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (dec_fire),
        .flush     (redirect_valid),
        .head      (head_entry),
        .count     (count)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (rsp_keep) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (rsp_drop) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (imem_req_valid && !imem_req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    instr_fetch_queue #(
        .XLEN       (32),
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (4),
        .PC_STEP    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall),
`endif
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // memory model: fixed latency, strictly in order, forgets everything on reset
    int          lat = 1;
    logic        acc_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic        rst_s = 1'b1;
    logic        pv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] pa [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_q [$];
    int          hs_cnt = 0;
    int          rsp_cnt = 0;
    int          acc_cnt = 0;

    always @(negedge clk) begin
        rst_s  = rst;
        acc_s  = !rst && imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (dec_valid && dec_ready) begin
                hs_cnt++;
                check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e);
                    check("dec_instr", dec_instr, word_of(e));
                end
            end
            if (!dec_valid) begin
                check("idle_zero", dec_pc | dec_instr, 32'd0);
            end
            if (acc_s) begin
                acc_cnt++;
                exp_q.push_back(addr_s);
            end
            if (redirect_valid) begin
                exp_q.delete();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = acc_s;
        pa[0] = addr_s;
        if (rst_s) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        end
        imem_rsp_valid = pv[lat-1];
        imem_rsp_data  = pv[lat-1] ? word_of(pa[lat-1]) : 32'd0;
        if (imem_rsp_valid) rsp_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input string tag);
        rst = 1'b1;
        lat = l;
        redirect_valid = 1'b0;
        tick(3);
        @(negedge clk);
        check({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_rst_dec_valid"}, 32'(dec_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hs_cnt = 0;
        rsp_cnt = 0;
        acc_cnt = 0;
        @(negedge clk);
        check({tag, "_rst_addr"}, imem_req_addr, TB_RESET_PC);
        check({tag, "_rst_req_valid_after"}, 32'(imem_req_valid), 32'd1);
    endtask

    task automatic wait_dec(input int budget, output int n);
        n = 0;
        while (!dec_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int v;

        // streaming with wrap from RESET_PC
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        do_reset(1, "t1");
        wait_dec(10, n);
        check("t1_fill_latency", 32'(n), 32'd2);
        check("t1_first_pc", dec_pc, TB_RESET_PC);
        @(negedge clk);
        check("t5_wrap_pc", dec_pc, 32'h0);
        v = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dec_valid) v++;
        end
        check("t1_throughput", 32'(v), 32'd16);

        // memory stall, then decode stall fills exactly the credit budget
        imem_req_ready = 1'b0;
        dec_ready = 1'b0;
        do_reset(1, "t2");
        tick(5);
        @(negedge clk);
        check("t2_stall_addr", imem_req_addr, TB_RESET_PC);
        check("t2_stall_valid", 32'(imem_req_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("t2_perf_stall", perf_stall, 32'd5);
`endif
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        tick(15);
        @(negedge clk);
        check("t2_req_count", 32'(acc_cnt), 32'd4);
        check("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
        check("t2_dec_valid_held", 32'(dec_valid), 32'd1);
        check("t2_head_pc", dec_pc, TB_RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check("t2_perf_fetched", perf_fetched, 32'd4);
`endif
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        tick(20);

        // redirect with two requests in flight
        do_reset(2, "t3");
        tick(10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick(1);
        redirect_valid = 1'b0;
        check("t3_flush", 32'(dec_valid), 32'd0);
        wait_dec(20, n);
        check("t3_timeout", 32'(n < 20), 32'd1);
        check("t3_first_pc", dec_pc, 32'h0000_0100);
        tick(10);

        // redirect coincident with accept and response, then back-to-back redirects
        do_reset(1, "t4");
        tick(6);
        @(negedge clk);
        check("t4_coincident", {30'd0, imem_req_valid && imem_req_ready, imem_rsp_valid}, 32'd3);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick(1);
        redirect_valid = 1'b0;
        wait_dec(20, n);
        check("t4_first_pc", dec_pc, 32'h0000_0200);
        tick(5);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick(1);
        redirect_pc = 32'hFFFF_FFF8;
        tick(1);
        redirect_valid = 1'b0;
        wait_dec(20, n);
        check("t4_latest_wins", dec_pc, 32'hFFFF_FFF8);
        for (int i = 0; i < 60; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            dec_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = {$urandom_range(0, 255), 2'b00};
            tick(1);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        dec_ready = 1'b1;
        tick(12);
        @(negedge clk);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("t4_idle", 32'(dec_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t4_perf_fetched", perf_fetched, 32'(hs_cnt));
        check("t4_perf_dropped", perf_dropped, 32'(rsp_cnt - hs_cnt));
`endif

        // reset in the middle of a stream
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_dec_valid", 32'(dec_valid), 32'd0);
        check("t6_addr", imem_req_addr, TB_RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_zero", perf_fetched | perf_dropped | perf_stall, 32'd0);
`endif
        wait_dec(10, n);
        check("t6_first_pc", dec_pc, TB_RESET_PC);
        tick(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
